// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (types only). Backpressure: n/a.
// Holds access sizes, FSM states, lane widths and the alignment rule.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int BYTE_W = 8;

    function automatic logic isMisaligned(input size_t sz, input logic [1:0] byteOff);
        logic bad;
        case (sz)
            SZ_WORD: bad = (byteOff != 2'b00);
            SZ_HALF: bad = byteOff[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Little-endian lane extraction for loads and lane merge for stores.
// Latency: purely combinational. Backpressure: none, no handshake.
// Load lanes are right-justified and zero-extended; store lanes come from the low bits.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  size_t              sizeSel,
    input  logic [1:0]         byteOff,
    input  logic [WORD_W-1:0]  loadWord,
    input  logic [WORD_W-1:0]  mergeBase,
    input  logic [WORD_W-1:0]  storeData,
    output logic [WORD_W-1:0]  loadData,
    output logic [WORD_W-1:0]  mergedWord
);

    localparam logic [WORD_W-1:0] BYTE_ONES = {{(WORD_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}};
    localparam logic [WORD_W-1:0] HALF_ONES = {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}};

    logic [4:0] byteShift;
    logic [4:0] halfShift;

    assign byteShift = {byteOff, 3'b000};
    assign halfShift = {byteOff[1], 4'b0000};

    always_comb begin
        loadData   = '0;
        mergedWord = mergeBase;
        case (sizeSel)
            SZ_WORD: begin
                loadData   = loadWord;
                mergedWord = storeData;
            end
            SZ_HALF: begin
                loadData   = (loadWord >> halfShift) & HALF_ONES;
                mergedWord = (mergeBase & ~(HALF_ONES << halfShift))
                           | ((storeData & HALF_ONES) << halfShift);
            end
            SZ_BYTE: begin
                loadData   = (loadWord >> byteShift) & BYTE_ONES;
                mergedWord = (mergeBase & ~(BYTE_ONES << byteShift))
                           | ((storeData & BYTE_ONES) << byteShift);
            end
            default: begin
                loadData   = '0;
                mergedWord = mergeBase;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory serving byte/half/word loads and read-modify-write stores.
// Latency: load ack 1+READ_LAT, store 2+READ_LAT, misaligned 1 cycle after acceptance.
// Backpressure: req is held by the initiator; only accepted in IDLE, busy high otherwise.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int READ_LAT    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        busy
);

    localparam int         IDX_W   = $clog2(DEPTH_WORDS);
    localparam int         OFF_W   = IDX_W + 2;
    localparam logic [2:0] LAST_RD = 3'(READ_LAT - 1);

    state_t             state;
    state_t             nextState;
    logic               wrQ;
    logic               misQ;
    size_t              sizeQ;
    logic [OFF_W-1:0]   addrQ;
    logic [WORD_W-1:0]  wdataQ;
    logic [WORD_W-1:0]  readWord;
    logic [2:0]         rdCnt;
    logic [WORD_W-1:0]  mem [DEPTH_WORDS];
    logic [IDX_W-1:0]   wordIdx;
    logic [WORD_W-1:0]  memWord;
    logic [WORD_W-1:0]  loadData;
    logic [WORD_W-1:0]  mergedWord;
    logic               reqMis;
    logic               readDone;
    logic               unusedAddrBits;

    // Bits above the storage span alias onto the same words.
    assign unusedAddrBits = ^addr[31:OFF_W];

    assign reqMis   = isMisaligned(size_t'(size), addr[1:0]);
    assign wordIdx  = addrQ[OFF_W-1:2];
    assign memWord  = mem[wordIdx];
    assign readDone = (state == READ) && (rdCnt == LAST_RD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        ack        = 1'b0;
        misaligned = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:  if (req) nextState = reqMis ? RESP : READ;
            READ:  if (rdCnt == LAST_RD) nextState = wrQ ? WRITE : RESP;
            WRITE: nextState = RESP;
            RESP: begin
                ack        = 1'b1;
                misaligned = misQ;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrQ      <= 1'b0;
            misQ     <= 1'b0;
            sizeQ    <= SZ_WORD;
            addrQ    <= '0;
            wdataQ   <= '0;
            readWord <= '0;
            rdCnt    <= '0;
            rdata    <= '0;
        end else begin
            if (state == IDLE && req) begin
                wrQ    <= wr;
                misQ   <= reqMis;
                sizeQ  <= size_t'(size);
                addrQ  <= addr[OFF_W-1:0];
                wdataQ <= wdata;
                rdCnt  <= '0;
            end
            if (state == READ) begin
                rdCnt <= rdCnt + 3'd1;
            end
            // Stores keep the old word for the merge; loads publish straight to rdata.
            if (readDone) begin
                if (wrQ) begin
                    readWord <= memWord;
                end else begin
                    rdata <= loadData;
                end
            end
        end
    end

    // Storage survives reset; an aborted store never reaches WRITE.
    always_ff @(posedge clock) begin
        if (state == WRITE) begin
            mem[wordIdx] <= mergedWord;
        end
    end

    dmem_lane_unit u_lane (
        .sizeSel    (sizeQ),
        .byteOff    (addrQ[1:0]),
        .loadWord   (memWord),
        .mergeBase  (readWord),
        .storeData  (wdataQ),
        .loadData   (loadData),
        .mergedWord (mergedWord)
    );

endmodule
